// File: rtl/fft_sample_framer_if.sv
// rtl/fft_sample_framer_if.sv - sample stream in, completed frame out, for fft_sample_framer
interface fft_sample_framer_if #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 32
);
  logic [WIDTH-1:0]          in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          frame_data [SAMPLES];
  logic                      frame_valid;
  logic                      frame_ready;
  logic [$clog2(SAMPLES):0]  fill_level;

  modport master (
    output in_data, in_valid, frame_ready,
    input  in_ready, frame_data, frame_valid, fill_level
  );

  modport slave (
    input  in_data, in_valid, frame_ready,
    output in_ready, frame_data, frame_valid, fill_level
  );
endinterface

// File: rtl/fft_sample_framer.sv
// rtl/fft_sample_framer.sv - ping-pong framer from serial samples to SAMPLES-word FFT input frames
// FRAMER_BITREV_EN: store each sample at the bit-reversed slot of its arrival index.
module fft_sample_framer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  fft_sample_framer_if.slave bus
);
  localparam int IW = $clog2(SAMPLES);

  generate
    if (SAMPLES < 2 || (SAMPLES & (SAMPLES - 1)) != 0) begin : g_bad_samples
      $error("fft_sample_framer: SAMPLES must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [2][SAMPLES];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             accept;
  logic             consume;
  logic [IW-1:0]    wr_slot;

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] idx);
    logic [IW-1:0] r;
`ifdef FRAMER_BITREV_EN
    for (int b = 0; b < IW; b++) begin
      r[b] = idx[IW-1-b];
    end
`else
    r = idx;
`endif
    return r;
  endfunction

  assign accept  = bus.in_valid && !bank_full_q[wr_bank_q];
  assign consume = bank_full_q[rd_bank_q] && bus.frame_ready;
  assign wr_slot = slot(wr_idx_q);

  // Accept and consume always target different banks, so both updates compose.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    bank_full_d = bank_full_q;
    if (consume) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    if (accept) begin
      if (wr_idx_q == IW'(SAMPLES - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_idx_d               = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      bank_full_q <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SAMPLES; s++) begin
          mem_q[b][s] <= '0;
        end
      end
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      bank_full_q <= bank_full_d;
      if (accept) begin
        mem_q[wr_bank_q][wr_slot] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready    = !bank_full_q[wr_bank_q];
  assign bus.frame_valid = bank_full_q[rd_bank_q];
  assign bus.fill_level  = {1'b0, wr_idx_q};

  always_comb begin
    for (int s = 0; s < SAMPLES; s++) begin
      bus.frame_data[s] = mem_q[rd_bank_q][s];
    end
  end
endmodule

// File: tb/tb_fft_sample_framer.sv
// tb/tb_fft_sample_framer.sv - randomized self-checking bench for fft_sample_framer against a frame-queue model
module tb_fft_sample_framer;
  localparam int N = 8;
  localparam int W = 32;

  typedef logic [N-1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fft_sample_framer_if #(.SAMPLES(N), .WIDTH(W)) bus ();

  fft_sample_framer #(.SAMPLES(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  // Model: completed frames waiting downstream plus the partial frame being gathered.
  frame_t fq[$];
  frame_t part;
  int     cnt = 0;

  function automatic int slot(input int i);
    int r;
`ifdef FRAMER_BITREV_EN
    r = 0;
    for (int b = 0; b < 3; b++) begin
      if (((i >> b) & 1) != 0) r = r | (1 << (2 - b));
    end
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      fq.delete();
      cnt = 0;
    end else begin
      bit acc, cons;
      acc  = bus.in_valid && (fq.size() < 2);
      cons = bus.frame_ready && (fq.size() > 0);
      if (cons) void'(fq.pop_front());
      if (acc) begin
        part[slot(cnt)] = bus.in_data;
        cnt++;
        if (cnt == N) begin
          fq.push_back(part);
          cnt = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(fq.size() < 2));
    chk("frame_valid", 32'(bus.frame_valid), 32'(fq.size() > 0));
    chk("fill_level", 32'(bus.fill_level), 32'(cnt));
    if (fq.size() > 0) begin
      for (int i = 0; i < N; i++) chk("frame_data", bus.frame_data[i], fq[0][i]);
    end
  end

  logic [W-1:0] t1_in  [N] = '{80, 70, 50, 40, 60, 10, 80, 90};
`ifdef FRAMER_BITREV_EN
  logic [W-1:0] t1_exp [N] = '{80, 60, 50, 80, 70, 10, 40, 90};
`else
  logic [W-1:0] t1_exp [N] = '{80, 70, 50, 40, 60, 10, 80, 90};
`endif

  task automatic chk_cleared(input string name);
    chk({name, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({name, "_frame_valid"}, 32'(bus.frame_valid), 0);
    chk({name, "_fill_level"}, 32'(bus.fill_level), 0);
    for (int i = 0; i < N; i++) chk({name, "_frame_data"}, bus.frame_data[i], 0);
  endtask

  initial begin
    int drops;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.frame_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    bus.frame_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = t1_in[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.frame_valid), 1);
    for (int i = 0; i < N; i++) begin
      chk("t1_data", bus.frame_data[i], t1_exp[i]);
      chk("t1_model", fq[0][i], t1_exp[i]);
    end
    @(negedge clk);
    chk("t1_pulse", 32'(bus.frame_valid), 0);

    bus.frame_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(100 + i);
      @(negedge clk);
    end
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_valid", 32'(bus.frame_valid), 1);
    chk("bp_fill", 32'(bus.fill_level), 0);
    bus.in_data = 32'd116;
    repeat (3) @(negedge clk);
    chk("bp_no_accept", 32'(bus.fill_level), 0);
    chk("bp_stable_0", bus.frame_data[0], 100);
    chk("bp_stable_7", bus.frame_data[7], 107);
    chk("bp_still_stalled", 32'(bus.in_ready), 0);

    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    chk("cons_valid", 32'(bus.frame_valid), 1);
    chk("cons_data_0", bus.frame_data[0], 108);
    chk("cons_data_7", bus.frame_data[7], 115);
    chk("cons_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("resume_fill", 32'(bus.fill_level), 1);

    bus.frame_ready = 1'b1;
    drops = 0;
    for (int i = 0; i < 4 * N - 1; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(negedge clk);
      if (!bus.in_ready) drops++;
    end
    bus.in_valid = 1'b0;
    chk("stream_drops", 32'(drops), 0);
    chk("stream_fill", 32'(bus.fill_level), 0);
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.in_data     = $urandom;
      bus.frame_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    bus.in_valid    = 1'b0;
    bus.frame_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("partial_fill", 32'(bus.fill_level), 5);
    #2 rst = 1'b1;
    #1 chk_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(200 + i);
      @(negedge clk);
    end
    chk("clean_valid", 32'(bus.frame_valid), 1);
    chk("clean_data_0", bus.frame_data[0], 200);
    chk("clean_data_7", bus.frame_data[7], 207);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(300 + i);
      if (i == N - 1) bus.frame_ready = 1'b1;
      @(negedge clk);
    end
    bus.in_valid    = 1'b0;
    bus.frame_ready = 1'b0;
    chk("bnd_valid", 32'(bus.frame_valid), 1);
    chk("bnd_data_0", bus.frame_data[0], 300);
    chk("bnd_data_7", bus.frame_data[7], 307);
    chk("bnd_in_ready", 32'(bus.in_ready), 1);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    chk("bnd_drained", 32'(bus.frame_valid), 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
